// File: rtl/seg_anim_pkg.sv
// Shared types and segment glyph tables for the seg_anim_mux display controller.
// Segment vectors are active-low cathodes ordered {a,b,c,d,e,f,g}; bit 6 is segment a.
package seg_anim_pkg;

   typedef enum logic [1:0] {
      WALK  = 2'd0,
      CLIMB = 2'd1,
      HEX   = 2'd2,
      BLINK = 2'd3
   } mode_e;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_ALL  = 7'h00;
   localparam logic [6:0] SEG_UPSQ = 7'b0011100;  // a,b,f,g lit
   localparam logic [6:0] SEG_DNSQ = 7'b1100010;  // c,d,e,g lit
   localparam logic [6:0] SEG_TOP  = 7'b0111111;  // a only
   localparam logic [6:0] SEG_BOT  = 7'b1110111;  // d only

   localparam logic [6:0] HEX_GLYPH [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
   };

   localparam logic [6:0] CLIMB_SEQ [8] = '{
      SEG_BOT, SEG_DNSQ, SEG_ALL, SEG_UPSQ, SEG_TOP, SEG_OFF, SEG_OFF, SEG_OFF
   };

endpackage

// File: rtl/seg_anim_mux_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, optional stability filter, registered rising-edge pulse.
// The filter is selected by defining SEG_ANIM_DEBOUNCE_EN; otherwise the synchronized level is used.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_press
);

`ifdef SEG_ANIM_DEBOUNCE_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_stable;
   logic            r_prev;
   logic            r_press;
   logic [DB_W-1:0] r_db_cnt;
   logic            w_level;

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // The level is accepted once it has differed from r_stable for DEBOUNCE_CYCLES cycles;
   // when the filter is disabled this logic has no load and is trimmed away.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stable <= 1'b0;
         r_db_cnt <= '0;
      end else if (r_sync2 == r_stable) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         r_stable <= r_sync2;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   assign w_level = FILTER_EN ? r_stable : r_sync2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev  <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_prev  <= w_level;
         r_press <= w_level & ~r_prev;
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/seg_anim_mux.sv
// Multiplexed 7-segment animation/hex display controller with tear-free valid/ready value loading.
// Define SEG_ANIM_DEBOUNCE_EN to enable the button debounce filter in btn_debounce.
module seg_anim_mux
   import seg_anim_pkg::*;
#(
   parameter int NUM_DIGITS      = 8,
   parameter int SCAN_DIV        = 16384,
   parameter int STEP_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    btnC,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic                    data_valid,
   output logic                    data_ready,
   output logic [1:0]              mode,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg
);

   localparam int POS_W  = $clog2(NUM_DIGITS);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int STEP_W = $clog2(STEP_DIV);
   localparam int S_W    = $clog2(2 * NUM_DIGITS);
   localparam int DATA_W = 4 * NUM_DIGITS;

   logic [SCAN_W-1:0]     r_scan_cnt;
   logic [POS_W-1:0]      r_pos;
   logic [STEP_W-1:0]     r_step_cnt;
   logic [15:0]           r_step;
   mode_e                 r_mode;
   logic [DATA_W-1:0]     r_disp;
   logic [DATA_W-1:0]     r_pend;
   logic                  r_pending;
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_seg;

   logic                  w_press;
   logic                  w_scan_tc;
   logic                  w_step_tc;
   logic                  w_frame;
   logic                  w_accept;
   logic [S_W-1:0]        w_walk_s;
   logic [2:0]            w_climb_idx;
   logic [3:0]            w_nib;
   logic [6:0]            w_seg_next;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (btnC),
      .o_press(w_press)
   );

   assign w_scan_tc = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign w_frame   = w_scan_tc && (r_pos == POS_W'(NUM_DIGITS - 1));
   assign w_step_tc = (r_step_cnt == STEP_W'(STEP_DIV - 1));
   assign w_accept  = data_valid && !r_pending;

   // Digit scan runs free; button presses never touch it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_pos      <= '0;
      end else if (w_scan_tc) begin
         r_scan_cnt <= '0;
         r_pos      <= (r_pos == POS_W'(NUM_DIGITS - 1)) ? '0 : r_pos + 1'b1;
      end else begin
         r_scan_cnt <= r_scan_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode     <= WALK;
         r_step     <= '0;
         r_step_cnt <= '0;
      end else if (w_press) begin
         r_mode     <= mode_e'(r_mode + 2'd1);
         r_step     <= '0;
         r_step_cnt <= '0;
      end else if (w_step_tc) begin
         r_step_cnt <= '0;
         r_step     <= r_step + 16'd1;
      end else begin
         r_step_cnt <= r_step_cnt + 1'b1;
      end
   end

   // Pending data is promoted only when it was already held at the start of a boundary cycle,
   // so an accept coinciding with a boundary waits for the next one.
   // NOTE: the wide data registers are reset too, because a reset must blank the hex value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_disp    <= '0;
         r_pend    <= '0;
         r_pending <= 1'b0;
      end else if (w_frame && r_pending) begin
         r_disp    <= r_pend;
         r_pending <= 1'b0;
      end else if (w_accept) begin
         r_pend    <= data_in;
         r_pending <= 1'b1;
      end
   end

   assign w_walk_s    = S_W'(r_step % 16'(2 * NUM_DIGITS));
   assign w_climb_idx = r_step[2:0] + 3'(r_pos);
   assign w_nib       = r_disp[{r_pos, 2'b00} +: 4];

   // NOTE: w_seg_next is given a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_seg_next = SEG_OFF;
      case (r_mode)
         WALK: begin
            if (w_walk_s < S_W'(NUM_DIGITS)) begin
               if (S_W'(r_pos) == w_walk_s) w_seg_next = SEG_UPSQ;
            end else if (S_W'(r_pos) == S_W'(2 * NUM_DIGITS - 1) - w_walk_s) begin
               w_seg_next = SEG_DNSQ;
            end
         end
         CLIMB: w_seg_next = CLIMB_SEQ[w_climb_idx];
         HEX:   w_seg_next = HEX_GLYPH[w_nib];
         BLINK: w_seg_next = r_step[2] ? SEG_OFF : HEX_GLYPH[w_nib];
      endcase
   end

   // an and seg are registered from the same r_pos so they always describe the same digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_an  <= '1;
         r_seg <= SEG_OFF;
      end else begin
         r_an  <= ~(NUM_DIGITS'(1) << r_pos);
         r_seg <= w_seg_next;
      end
   end

   assign data_ready = !r_pending;
   assign mode       = r_mode;
   assign an         = r_an;
   assign seg        = r_seg;

endmodule

// File: tb/tb_seg_anim_mux.sv
// Directed self-checking bench for seg_anim_mux with N=4, SCAN_DIV=4, STEP_DIV=16, debounce off.
// Cycle index k counts clock edges since reset release; all expectations are derived from k.
module tb_seg_anim_mux;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          btnC;
   logic [4*N-1:0] data_in;
   logic          data_valid;
   logic          data_ready;
   logic [1:0]    mode;
   logic [N-1:0]  an;
   logic [6:0]    seg;

   int k = 0;
   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      int         k;
      logic [3:0] an;
      logic [6:0] seg;
   } vec_t;

   vec_t vecs[14];

   seg_anim_mux #(
      .NUM_DIGITS     (N),
      .SCAN_DIV       (4),
      .STEP_DIV       (16),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btnC      (btnC),
      .data_in   (data_in),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .mode      (mode),
      .an        (an),
      .seg       (seg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", k);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, k);
      end
   endtask

   task automatic check_disp(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg);
      check({name, "_an"}, 32'(an), 32'(exp_an));
      check({name, "_seg"}, 32'(seg), 32'(exp_seg));
   endtask

   // Returns at the falling edge after clock edge number 'target'.
   task automatic wait_k(input int target);
      for (int i = 0; i < 2000 && k < target; i++) @(negedge clk);
      if (k < target) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_k: stuck at cycle %0d, want %0d", k, target);
      end
   endtask

   task automatic press(input int hold);
      int k0;
      k0 = k;
      btnC = 1'b1;
      wait_k(k0 + hold);
      btnC = 1'b0;
      wait_k(k0 + hold + 3);
   endtask

   initial begin
      int k0;

      // Scan/WALK vectors: sample after edge k shows pos=((k-1)/4)%4, step=(k-1)/16.
      vecs[0]  = '{1,  4'b1110, 7'h1C};
      vecs[1]  = '{4,  4'b1110, 7'h1C};
      vecs[2]  = '{5,  4'b1101, 7'h7F};
      vecs[3]  = '{9,  4'b1011, 7'h7F};
      vecs[4]  = '{13, 4'b0111, 7'h7F};
      vecs[5]  = '{17, 4'b1110, 7'h7F};
      vecs[6]  = '{21, 4'b1101, 7'h1C};
      vecs[7]  = '{61, 4'b0111, 7'h1C};
      vecs[8]  = '{77, 4'b0111, 7'h62};
      vecs[9]  = '{81, 4'b1110, 7'h7F};
      vecs[10] = '{85, 4'b1101, 7'h7F};
      vecs[11] = '{89, 4'b1011, 7'h62};
      vecs[12] = '{92, 4'b1011, 7'h62};
      vecs[13] = '{93, 4'b0111, 7'h7F};

      rst_n      = 1'b0;
      btnC       = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      repeat (3) @(negedge clk);
      check_disp("reset", 4'b1111, 7'h7F);
      check("reset_mode", 32'(mode), 32'd0);
      check("reset_ready", 32'(data_ready), 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         wait_k(vecs[i].k);
         check_disp($sformatf("walk_scan%0d", i), vecs[i].an, vecs[i].seg);
      end

      // Press 1: WALK -> CLIMB, step cleared, scan undisturbed.
      k0 = k;
      btnC = 1'b1;
      wait_k(k0 + 1);
      btnC = 1'b0;
      wait_k(k0 + 2);
      check("press1_early_mode", 32'(mode), 32'd0);
      wait_k(k0 + 4);
      check("press1_mode", 32'(mode), 32'd1);
      wait_k(101);
      check_disp("climb_d1", 4'b1101, 7'h62);
      wait_k(105);
      check_disp("climb_d2", 4'b1011, 7'h00);
      wait_k(109);
      check_disp("climb_d3", 4'b0111, 7'h1C);

      press(1);
      check("press2_mode", 32'(mode), 32'd2);
      wait_k(115);
      check_disp("hex_init", 4'b1110, 7'h01);

      // Mid-frame load of 3A0F, applied at the boundary edge 144.
      wait_k(133);
      data_in    = 16'h3A0F;
      data_valid = 1'b1;
      wait_k(134);
      check("load_ready_drop", 32'(data_ready), 32'd0);
      data_in = 16'hFFFF;
      wait_k(140);
      data_valid = 1'b0;
      wait_k(143);
      check("load_ready_held", 32'(data_ready), 32'd0);
      check_disp("load_old_d3", 4'b0111, 7'h01);
      wait_k(144);
      check("load_ready_rise", 32'(data_ready), 32'd1);
      wait_k(145);
      check_disp("load_d0_F", 4'b1110, 7'h38);
      wait_k(149);
      check_disp("load_d1_0", 4'b1101, 7'h01);
      wait_k(153);
      check_disp("load_d2_A", 4'b1011, 7'h08);
      wait_k(157);
      check_disp("load_d3_3", 4'b0111, 7'h06);

      // Accept on the boundary edge 176: old value stays one more frame.
      wait_k(175);
      data_in    = 16'h1234;
      data_valid = 1'b1;
      wait_k(176);
      data_valid = 1'b0;
      check("bnd_ready_drop", 32'(data_ready), 32'd0);
      wait_k(177);
      check_disp("bnd_old_d0", 4'b1110, 7'h38);
      wait_k(189);
      check_disp("bnd_old_d3", 4'b0111, 7'h06);
      wait_k(191);
      check("bnd_ready_held", 32'(data_ready), 32'd0);
      wait_k(192);
      check("bnd_ready_rise", 32'(data_ready), 32'd1);
      wait_k(193);
      check_disp("bnd_new_d0", 4'b1110, 7'h4C);
      wait_k(205);
      check_disp("bnd_new_d3", 4'b0111, 7'h4F);

      // Press 3: BLINK; mode register changes at edge 209, step restarts there.
      press(1);
      check("press3_mode", 32'(mode), 32'd3);
      wait_k(210);
      check_disp("blink_on_d0", 4'b1110, 7'h4C);
      wait_k(274);
      check_disp("blink_off_d0", 4'b1110, 7'h7F);
      wait_k(283);
      check_disp("blink_off_d2", 4'b1011, 7'h7F);

      // Press 4 held for 20 cycles: one edge only, mode wraps to WALK.
      press(20);
      check("press4_hold_mode", 32'(mode), 32'd0);

      // Reset while a load is pending.
      wait_k(309);
      data_in    = 16'hBEEF;
      data_valid = 1'b1;
      wait_k(310);
      data_valid = 1'b0;
      check("rst_pend_ready", 32'(data_ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      check_disp("rst_mid", 4'b1111, 7'h7F);
      check("rst_mid_ready", 32'(data_ready), 32'd1);
      check("rst_mid_mode", 32'(mode), 32'd0);
      rst_n = 1'b1;

      wait_k(2);
      press(1);
      press(1);
      check("rst_hex_mode", 32'(mode), 32'd2);
      for (int i = 0; i < 4; i++) begin
         wait_k(33 + 4 * i);
         check_disp($sformatf("rst_disp_zero%0d", i), ~(4'b0001 << i), 7'h01);
      end
      check("rst_final_ready", 32'(data_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_anim_mux.md
# seg_anim_mux

Parametrised 7-segment animation and display controller for the board's multiplexed display. Scans `NUM_DIGITS` common-anode digits and renders one of four modes: walking square, climbing bar, hex value, blinking hex value. Mode advances on a button press. The hex value is loaded through a valid/ready handshake and applied only at frame boundaries, so the display never tears. Sits between the top-level board wrapper and the `an`/`seg` pins.

## Interface
- `NUM_DIGITS`, 8, number of multiplexed digits (2..16).
- `SCAN_DIV`, 16384, clocks per digit scan slot (≥2).
- `STEP_DIV`, 100000, clocks per animation step (≥2).
- `DEBOUNCE_CYCLES`, 1000000, stable cycles required to accept a button level (used only with the debounce macro).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `btnC`  in  1  raw asynchronous mode button, active-high.
- `data_in`  in  4*NUM_DIGITS  hex value; nibble p goes to digit p.
- `data_valid`  in  1  `data_in` offered.
- `data_ready`  out  1  block can accept `data_in`.
- `mode`  out  2  current mode.
- `an`  out  NUM_DIGITS  digit enables, active-low, one-cold.
- `seg`  out  7  cathodes {a,b,c,d,e,f,g}, active-low, `seg[6]`=a.

## Operation
- Scan: `scan_cnt` counts 0..SCAN_DIV-1. At the terminal count, `pos` advances by 1 mod NUM_DIGITS.
- Frame boundary: the cycle where `scan_cnt` is terminal and `pos`==NUM_DIGITS-1.
- Step: `step_cnt` counts 0..STEP_DIV-1. Its terminal count increments the 16-bit `step`, which wraps.
- Mode WALK (0): s = step mod 2N.
  - s<N: digit s shows upsquare (a,b,f,g lit).
  - s≥N: digit 2N-1-s shows downsquare (c,d,e,g lit).
  - All other digits are off.
- Mode CLIMB (1): digit p shows CLIMB[(step+p) mod 8], where CLIMB = {d only, downsquare, all lit, upsquare, a only, off, off, off}.
- Mode HEX (2): digit p shows the standard hex glyph of display-register nibble p.
- Mode BLINK (3): same as HEX while `step[2]`==0; all segments off while `step[2]`==1.
- Button:
  - `btnC` passes through a 2-flop synchronizer, then an optional debounce filter, then a rising-edge detector.
  - A press sets mode ← (mode+1) mod 4 and clears `step` and `step_cnt`.
  - The scan (`pos`, `scan_cnt`) is never disturbed by a press.
- Load handshake:
  - Accept occurs on `data_valid && data_ready`: data is captured into the pending register, `pending` is set, and `data_ready` drops the next cycle.
  - At a frame boundary with `pending` already set at the start of that cycle: pending is copied to the display register, `pending` clears, and `data_ready` rises the next cycle.
  - An accept in the same cycle as a frame boundary is not applied at that boundary; it is applied at the following boundary.
- `data_in` is ignored while `data_ready`=0.
- Reset values: `an`=all ones, `seg`=7'h7F, `mode`=0, `data_ready`=1, display and pending registers=0, `pending`=0, `pos`=0, `step`=0, and all counters=0.
- Reset asserted mid-frame or mid-handshake discards pending data and returns all state to the reset values above on the next edge.

## Timing
- `an` and `seg` are registered from the same `pos`. They change together, one cycle after `pos` updates, and are never mismatched.
- Mode change is visible on `mode` one cycle after the detected edge.
- Press-to-edge latency: 3 cycles without debounce; 2+DEBOUNCE_CYCLES+1 cycles with debounce.
- Worst-case load-to-display latency: N·SCAN_DIV + 2 cycles.
- Holding the button generates no repeat edges.

## Configuration
- `SEG_ANIM_DEBOUNCE_EN` defined: the synchronized button level is accepted only after it has been stable for DEBOUNCE_CYCLES consecutive cycles. Glitches shorter than that produce no mode change.
- Not defined: the synchronized level feeds the edge detector directly. Every synchronized rising edge advances the mode. Use this for simulation.

## Structure
- Package `seg_anim_pkg` holds:
  - the mode enum (WALK, CLIMB, HEX, BLINK);
  - segment constants (OFF, ALL, UPSQ, DNSQ, TOP, BOT);
  - the 16-entry hex glyph table;
  - the 8-entry CLIMB table.
- Sub-module `btn_debounce`: synchronizer, optional filter, and rising-edge pulse. Instantiated once.

## Test plan
Parameters: N=4, SCAN_DIV=4, STEP_DIV=16, macro off.
- Reset release → `an`=4'b1111 and `seg`=7'h7F during reset. Afterwards `an` cycles 1110, 1101, 1011, 0111, each slot held for 4 clocks.
- Mode WALK, step=5 → digit 2 shows downsquare (`seg`=7'b1100010); the other three digits show 7'h7F.
- Press `btnC` for 1 cycle (synchronized) → `mode` 0→1 after 3 cycles and `step`=0. Four presses return `mode` to 0.
- HEX mode, load 16'h3A0F mid-frame → `data_ready` drops for one frame. At the next boundary the digits show F, 0, A, 3 (digit0=F), and `data_ready`=1 one cycle later.
- Accept coinciding with a frame boundary → old value is displayed for one more full frame, then the new value.
- `rst_n`=0 while `pending`=1 → pending data is lost, `data_ready`=1, and the display register is 0.
